// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage RV32 core.
// Arbitrates cache freezes, MUL/DIV occupancy, taken-branch flushes and load-use bubbles.
module hazard_stall_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        ex_md_op,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        exmem_flush,
  output logic        memwb_stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic exmem_flush;
    logic memwb_stall;
    logic md_done;
  } ctl_t;

  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  ctl_t ctl;
  logic cs;
  logic load_use;
  logic md_stall;

  assign cs = icache_stall | dcache_stall;

  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_use_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_use_rs2 && (id_rs2_addr == ex_rd_addr)));

  // Front end held while the op occupies EX; a bubble goes to MEM behind it.
  assign md_stall = ((state_q == IDLE) && ex_md_op) ||
                    ((state_q == MD_BUSY) && (cnt_q > 4'd1));

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (cs) begin
      ctl.pc_stall    = 1'b1;
      ctl.ifid_stall  = 1'b1;
      ctl.idex_stall  = 1'b1;
      ctl.exmem_stall = 1'b1;
      ctl.memwb_stall = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_md_op) begin
            state_d = MD_BUSY;
            cnt_d   = MD_INIT;
          end
        end
        MD_BUSY: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            ctl.md_done = 1'b1;
            state_d     = IDLE;
            cnt_d       = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase

      if (md_stall) begin
        ctl.pc_stall    = 1'b1;
        ctl.ifid_stall  = 1'b1;
        ctl.idex_stall  = 1'b1;
        ctl.exmem_flush = 1'b1;
      end else if (ex_branch_taken) begin
        // Redirect squashes both younger slots; load-use in ID is moot.
        ctl.ifid_flush = 1'b1;
        ctl.idex_flush = 1'b1;
      end else if (load_use) begin
        ctl.pc_stall   = 1'b1;
        ctl.ifid_stall = 1'b1;
        ctl.idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, ctl.pc_stall};
    flush_cnt_d = flush_cnt_q + {31'd0, ctl.ifid_flush};
    if (rst) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_stall    = ctl.pc_stall;
  assign ifid_stall  = ctl.ifid_stall;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_stall  = ctl.idex_stall;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_stall = ctl.exmem_stall;
  assign exmem_flush = ctl.exmem_flush;
  assign memwb_stall = ctl.memwb_stall;
  assign md_done     = ctl.md_done;
  assign md_busy     = !rst && (state_q == MD_BUSY);
  assign stall_cnt   = rst ? 32'd0 : stall_cnt_q;
  assign flush_cnt   = rst ? 32'd0 : flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MD_LAT=4.
// Output vector order: pc_s ifid_s ifid_f idex_s idex_f exmem_s exmem_f memwb_s md_busy md_done.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_stall, dcache_stall;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_md_op;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic        exmem_stall, exmem_flush, memwb_stall, md_busy, md_done;
  logic [31:0] stall_cnt, flush_cnt;

  int errs = 0;
  int chks = 0;

  localparam logic [9:0] O_NONE  = 10'b00000_00000;
  localparam logic [9:0] O_CACHE = 10'b11010_10100;
  localparam logic [9:0] O_CBUSY = 10'b11010_10110;
  localparam logic [9:0] O_LU    = 10'b11001_00000;
  localparam logic [9:0] O_BR    = 10'b00101_00000;
  localparam logic [9:0] O_MDI   = 10'b11010_01000;
  localparam logic [9:0] O_MDB   = 10'b11010_01010;
  localparam logic [9:0] O_DONE  = 10'b00000_00011;

  hazard_stall_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_md_op(ex_md_op),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .exmem_flush(exmem_flush),
    .memwb_stall(memwb_stall), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  wire [9:0] ov = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                   exmem_stall, exmem_flush, memwb_stall, md_busy, md_done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs checked 3 units later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic clr;
    icache_stall = 0; dcache_stall = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd_addr = 0; ex_mem_read = 0; ex_branch_taken = 0; ex_md_op = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1; ex_rd_addr = rd; id_rs2_addr = 5'd5; id_use_rs2 = 1;
  endtask

  initial begin
    clr();
    rst = 1; dcache_stall = 1;
    tick();
    // Reset held two cycles with a D-cache miss present
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_out", {22'd0, ov}, {22'd0, O_NONE});
      chk("rst_scnt", stall_cnt, 32'd0);
      tick();
    end
    rst = 0; dcache_stall = 0;
    settle();
    chk("post_rst_idle", {22'd0, ov}, {22'd0, O_NONE});
    chk("post_rst_scnt", stall_cnt, 32'd0);
    chk("post_rst_fcnt", flush_cnt, 32'd0);
    tick();

    // Load-use on rs2
    set_lu(5'd5);
    settle(); chk("lu_rs2", {22'd0, ov}, {22'd0, O_LU});
    tick();
    chk("lu_scnt", stall_cnt, 32'd1);
    ex_rd_addr = 0;
    settle(); chk("lu_x0", {22'd0, ov}, {22'd0, O_NONE});
    tick();
    chk("lu_x0_scnt", stall_cnt, 32'd1);
    // Load-use on rs1, then same match with use_rs1 cleared
    clr();
    ex_mem_read = 1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_use_rs1 = 1;
    settle(); chk("lu_rs1", {22'd0, ov}, {22'd0, O_LU});
    tick();
    id_use_rs1 = 0;
    settle(); chk("lu_rs1_unused", {22'd0, ov}, {22'd0, O_NONE});
    ex_mem_read = 0; id_use_rs1 = 1;
    settle(); chk("lu_not_load", {22'd0, ov}, {22'd0, O_NONE});
    tick();
    chk("lu_rs1_scnt", stall_cnt, 32'd2);

    // Branch masks load-use
    clr();
    set_lu(5'd5); ex_branch_taken = 1;
    settle(); chk("br_vs_lu", {22'd0, ov}, {22'd0, O_BR});
    tick();
    chk("br_fcnt", flush_cnt, 32'd1);
    chk("br_scnt", stall_cnt, 32'd2);
    clr();

    // MUL/DIV, MD_LAT=4
    ex_md_op = 1;
    settle(); chk("md_T0", {22'd0, ov}, {22'd0, O_MDI}); tick();
    settle(); chk("md_T1", {22'd0, ov}, {22'd0, O_MDB}); tick();
    settle(); chk("md_T2", {22'd0, ov}, {22'd0, O_MDB}); tick();
    settle(); chk("md_T3", {22'd0, ov}, {22'd0, O_DONE}); tick();
    ex_md_op = 0;
    settle(); chk("md_T4", {22'd0, ov}, {22'd0, O_NONE});
    chk("md_scnt", stall_cnt, 32'd5);
    tick();

    // MUL/DIV with D-cache miss at T+1, T+2
    ex_md_op = 1;
    settle(); chk("mdc_T0", {22'd0, ov}, {22'd0, O_MDI}); tick();
    dcache_stall = 1;
    settle(); chk("mdc_T1", {22'd0, ov}, {22'd0, O_CBUSY}); tick();
    settle(); chk("mdc_T2", {22'd0, ov}, {22'd0, O_CBUSY}); tick();
    dcache_stall = 0;
    settle(); chk("mdc_T3", {22'd0, ov}, {22'd0, O_MDB}); tick();
    settle(); chk("mdc_T4", {22'd0, ov}, {22'd0, O_MDB}); tick();
    settle(); chk("mdc_T5", {22'd0, ov}, {22'd0, O_DONE}); tick();
    ex_md_op = 0;
    settle(); chk("mdc_T6", {22'd0, ov}, {22'd0, O_NONE});
    chk("mdc_scnt", stall_cnt, 32'd10);
    tick();

    // I-cache miss overrides pending branch and load-use
    set_lu(5'd5); ex_branch_taken = 1; icache_stall = 1;
    settle(); chk("ic_prio", {22'd0, ov}, {22'd0, O_CACHE}); tick();
    clr();
    settle();
    chk("ic_scnt", stall_cnt, 32'd11);
    chk("ic_fcnt", flush_cnt, 32'd1);
    tick();

    // Reset pulse at T+1 of a MUL/DIV op, op still present afterwards
    ex_md_op = 1;
    settle(); chk("mdr_T0", {22'd0, ov}, {22'd0, O_MDI}); tick();
    rst = 1;
    settle(); chk("mdr_rst", {22'd0, ov}, {22'd0, O_NONE});
    chk("mdr_rst_scnt", stall_cnt, 32'd0);
    tick();
    rst = 0;
    settle(); chk("mdr_reissue", {22'd0, ov}, {22'd0, O_MDI});
    chk("mdr_scnt0", stall_cnt, 32'd0);
    tick();
    settle(); chk("mdr_T1", {22'd0, ov}, {22'd0, O_MDB}); tick();
    settle(); chk("mdr_T2", {22'd0, ov}, {22'd0, O_MDB}); tick();
    settle(); chk("mdr_T3", {22'd0, ov}, {22'd0, O_DONE});
    // Branch in the done cycle is honoured since MD no longer stalls
    ex_branch_taken = 1;
    settle(); chk("mdr_done_br", {22'd0, ov}, {22'd0, O_BR | O_DONE}); tick();
    clr();
    settle();
    chk("mdr_scnt", stall_cnt, 32'd3);
    chk("mdr_fcnt", flush_cnt, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
